// File: rtl/ub_arith_pkg.sv
// Shared arithmetic types and constants for the bit-serial datapath blocks.
package ub_arith_pkg;

   localparam int DEF_WIDTH = 23;
   localparam int CNT_W     = $clog2(DEF_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ub_serial_rcs_if.sv
// Operand and result handshake bundle for the serial subtractor.
interface ub_serial_rcs_if
   import ub_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   d;

   modport master (
      output in_valid, x, y, bin, out_ready,
      input  in_ready, out_valid, d
   );

   modport slave (
      input  in_valid, x, y, bin, out_ready,
      output in_ready, out_valid, d
   );

endinterface

// File: rtl/ub_fs_cell.sv
// Combinational full subtractor: d = x - y - z, borrow out on b.
// Port order mirrors the full-adder cell of the companion ripple-carry adder.
module ub_fs_cell (
   output logic b,
   output logic d,
   input  logic x,
   input  logic y,
   input  logic z
);

   assign d = x ^ y ^ z;
   assign b = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/ub_serial_rcs.sv
// Bit-serial ripple-borrow subtractor, D = X - Y - BIN, one bit per clock.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one difference bit per cycle, LSB first, cnt = bit index
// DONE  | result held on d with out_valid high until out_ready
module ub_serial_rcs
   import ub_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic              clk,
   input logic              rst,
   ub_serial_rcs_if.slave   bus
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] xsh;
   logic [WIDTH-1:0] ysh;
   logic [WIDTH-1:0] rsh;
   logic [WIDTH:0]   d_q;
   logic             borrow;
   logic             out_valid_q;
   logic [CW-1:0]    cnt;
   logic             cell_d;
   logic             cell_b;

   ub_fs_cell u_cell (
      .b (cell_b),
      .d (cell_d),
      .x (xsh[0]),
      .y (ysh[0]),
      .z (borrow)
   );

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.d         = d_q;

   // Sequencer, operand shifters, borrow flop and result registers.
   // The result shifter is kept apart from d_q so that d holds the previous
   // answer while the next operation is being computed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         xsh         <= '0;
         ysh         <= '0;
         rsh         <= '0;
         d_q         <= '0;
         borrow      <= 1'b0;
         out_valid_q <= 1'b0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  xsh    <= bus.x;
                  ysh    <= bus.y;
                  borrow <= bus.bin;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               rsh    <= {cell_d, rsh[WIDTH-1:1]};
               borrow <= cell_b;
               xsh    <= xsh >> 1;
               ysh    <= ysh >> 1;
               if (cnt == CW'(WIDTH - 1)) begin
                  d_q         <= {cell_b, cell_d, rsh[WIDTH-1:1]};
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
